// File: rtl/cnn_pkg.sv
// Shared definitions for the MNIST CNN pixel feeder: FSM encoding, decision
// format and default image geometry.
package cnn_pkg;

   localparam int DECISION_BITS = 4;
   localparam logic [DECISION_BITS-1:0] DECISION_TIMEOUT = 4'hF;

   localparam int DEFAULT_IMG_W = 28;
   localparam int DEFAULT_IMG_H = 28;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_STREAM   = 2'd1;
   localparam state_t ST_GAP      = 2'd2;
   localparam state_t ST_WAIT_RES = 2'd3;

   // Counter width able to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/cnn_image_feeder_if.sv
// Bundle of the feeder's load, control, pixel-stream and result signals;
// master is the feeder, slave is the surrounding pipeline/host.
interface cnn_image_feeder_if #(
   parameter int PIXEL_BITS = 8,
   parameter int SLOT_BITS  = 2,
   parameter int ADDR_BITS  = 10
);
   import cnn_pkg::*;

   logic                     wr_en;
   logic [SLOT_BITS-1:0]     wr_slot;
   logic [ADDR_BITS-1:0]     wr_addr;
   logic [PIXEL_BITS-1:0]    wr_data;
   logic                     start;
   logic [SLOT_BITS-1:0]     start_slot;
   logic                     busy;
   logic                     pix_valid;
   logic                     pix_ready;
   logic [PIXEL_BITS-1:0]    pix_data;
   logic                     pix_last;
   logic                     res_in_valid;
   logic [DECISION_BITS-1:0] res_in_decision;
   logic                     res_valid;
   logic [SLOT_BITS-1:0]     res_slot;
   logic [DECISION_BITS-1:0] res_decision;
   logic                     res_timeout;
   logic                     err_wr_conflict;

   modport master (
      input  wr_en, wr_slot, wr_addr, wr_data, start, start_slot,
             pix_ready, res_in_valid, res_in_decision,
      output busy, pix_valid, pix_data, pix_last,
             res_valid, res_slot, res_decision, res_timeout, err_wr_conflict
   );

   modport slave (
      output wr_en, wr_slot, wr_addr, wr_data, start, start_slot,
             pix_ready, res_in_valid, res_in_decision,
      input  busy, pix_valid, pix_data, pix_last,
             res_valid, res_slot, res_decision, res_timeout, err_wr_conflict
   );

endinterface

// File: rtl/cnn_image_mem.sv
// Slot-addressed image store: one write port, one asynchronous read port.
// Contents are deliberately not reset so images survive a pipeline abort.
module cnn_image_mem #(
   parameter int PIXEL_BITS = 8,
   parameter int NUM_SLOTS  = 4,
   parameter int SLOT_BITS  = 2,
   parameter int ADDR_BITS  = 10,
   parameter int NPIX       = 784
)(
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [SLOT_BITS-1:0]  wr_slot,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [PIXEL_BITS-1:0] wr_data,
   input  logic [SLOT_BITS-1:0]  rd_slot,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [PIXEL_BITS-1:0] rd_data
);

   localparam logic [ADDR_BITS:0] NPIX_EXT = (ADDR_BITS+1)'(NPIX);

   logic [PIXEL_BITS-1:0] mem_q [NUM_SLOTS][NPIX];

   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < NPIX_EXT)) begin
         mem_q[wr_slot][wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < NPIX_EXT) begin
         rd_data = mem_q[rd_slot][rd_addr];
      end else begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/cnn_image_feeder.sv
// Streams a stored image raster-order over a valid/ready pixel port, then
// waits for the classifier decision (or a timeout) and reports it per slot.
module cnn_image_feeder
   import cnn_pkg::*;
#(
   parameter int PIXEL_BITS = 8,
   parameter int IMG_W      = DEFAULT_IMG_W,
   parameter int IMG_H      = DEFAULT_IMG_H,
   parameter int NUM_SLOTS  = 4,
   parameter int SLOT_BITS  = 2,
   parameter int ADDR_BITS  = 10,
   parameter int GAP_CYCLES = 0,
   parameter int TIMEOUT    = 4096
)(
   input logic                clk,
   input logic                rst,
   cnn_image_feeder_if.master bus
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = cnt_width((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES);
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NPIX - 1);
   localparam logic [CNT_W-1:0]     TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   state_t                   state_d, state_q;
   logic [SLOT_BITS-1:0]     act_slot_d, act_slot_q;
   logic [ADDR_BITS-1:0]     idx_d, idx_q;
   logic [CNT_W-1:0]         cnt_d, cnt_q;
   logic                     busy_d, busy_q;
   logic                     pix_valid_d, pix_valid_q;
   logic [PIXEL_BITS-1:0]    pix_data_d, pix_data_q;
   logic                     pix_last_d, pix_last_q;
   logic                     res_valid_d, res_valid_q;
   logic [SLOT_BITS-1:0]     res_slot_d, res_slot_q;
   logic [DECISION_BITS-1:0] res_decision_d, res_decision_q;
   logic                     res_timeout_d, res_timeout_q;
   logic                     err_wr_conflict_d, err_wr_conflict_q;

   logic                     mem_we;
   logic [SLOT_BITS-1:0]     rd_slot;
   logic [ADDR_BITS-1:0]     rd_addr;
   logic [PIXEL_BITS-1:0]    rd_data;

   cnn_image_mem #(
      .PIXEL_BITS (PIXEL_BITS),
      .NUM_SLOTS  (NUM_SLOTS),
      .SLOT_BITS  (SLOT_BITS),
      .ADDR_BITS  (ADDR_BITS),
      .NPIX       (NPIX)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_slot (bus.wr_slot),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_slot (rd_slot),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // A write into the slot being streamed would tear the frame, so it is dropped.
   always_comb begin
      err_wr_conflict_d = bus.wr_en && (state_q != ST_IDLE) && (bus.wr_slot == act_slot_q);
      mem_we            = bus.wr_en && !err_wr_conflict_d;
   end

   // idx_q is the index of the next pixel to load; pixel 0 is loaded on start.
   always_comb begin
      state_d        = state_q;
      act_slot_d     = act_slot_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      pix_valid_d    = pix_valid_q;
      pix_data_d     = pix_data_q;
      pix_last_d     = pix_last_q;
      res_valid_d    = 1'b0;
      res_slot_d     = res_slot_q;
      res_decision_d = res_decision_q;
      res_timeout_d  = res_timeout_q;
      rd_slot        = act_slot_q;
      rd_addr        = idx_q;

      case (state_q)
         ST_IDLE: begin
            rd_slot = bus.start_slot;
            rd_addr = '0;
            if (bus.start) begin
               state_d     = ST_STREAM;
               act_slot_d  = bus.start_slot;
               idx_d       = ADDR_BITS'(1);
               pix_valid_d = 1'b1;
               pix_data_d  = rd_data;
               pix_last_d  = (LAST_IDX == '0);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (!pix_valid_q || bus.pix_ready) begin
               if (pix_valid_q && pix_last_q) begin
                  pix_valid_d = 1'b0;
                  pix_last_d  = 1'b0;
                  cnt_d       = '0;
                  state_d     = (GAP_CYCLES > 0) ? ST_GAP : ST_WAIT_RES;
               end else begin
                  pix_valid_d = 1'b1;
                  pix_data_d  = rd_data;
                  pix_last_d  = (idx_q == LAST_IDX);
                  idx_d       = idx_q + ADDR_BITS'(1);
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_WAIT_RES;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_RES: begin
            // WAIT_RES lasts at most TIMEOUT cycles; a real result on the last one wins.
            if (bus.res_in_valid) begin
               res_valid_d    = 1'b1;
               res_slot_d     = act_slot_q;
               res_decision_d = bus.res_in_decision;
               res_timeout_d  = 1'b0;
               state_d        = ST_IDLE;
            end else if (cnt_q == TO_LAST) begin
               res_valid_d    = 1'b1;
               res_slot_d     = act_slot_q;
               res_decision_d = DECISION_TIMEOUT;
               res_timeout_d  = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; memory is outside this reset on purpose.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         act_slot_q        <= '0;
         idx_q             <= '0;
         cnt_q             <= '0;
         busy_q            <= 1'b0;
         pix_valid_q       <= 1'b0;
         pix_data_q        <= '0;
         pix_last_q        <= 1'b0;
         res_valid_q       <= 1'b0;
         res_slot_q        <= '0;
         res_decision_q    <= '0;
         res_timeout_q     <= 1'b0;
         err_wr_conflict_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         act_slot_q        <= act_slot_d;
         idx_q             <= idx_d;
         cnt_q             <= cnt_d;
         busy_q            <= busy_d;
         pix_valid_q       <= pix_valid_d;
         pix_data_q        <= pix_data_d;
         pix_last_q        <= pix_last_d;
         res_valid_q       <= res_valid_d;
         res_slot_q        <= res_slot_d;
         res_decision_q    <= res_decision_d;
         res_timeout_q     <= res_timeout_d;
         err_wr_conflict_q <= err_wr_conflict_d;
      end
   end

   assign bus.busy            = busy_q;
   assign bus.pix_valid       = pix_valid_q;
   assign bus.pix_data        = pix_data_q;
   assign bus.pix_last        = pix_last_q;
   assign bus.res_valid       = res_valid_q;
   assign bus.res_slot        = res_slot_q;
   assign bus.res_decision    = res_decision_q;
   assign bus.res_timeout     = res_timeout_q;
   assign bus.err_wr_conflict = err_wr_conflict_q;

endmodule

// File: tb/tb_cnn_image_feeder.sv
// Directed bench for cnn_image_feeder: 28x28 image, TIMEOUT=64, no gap.
module tb_cnn_image_feeder;

   localparam int NPIX = 784;
   localparam int TO   = 64;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   cnn_image_feeder_if #(.PIXEL_BITS(8), .SLOT_BITS(2), .ADDR_BITS(10)) bus ();

   cnn_image_feeder #(
      .PIXEL_BITS (8),
      .IMG_W      (28),
      .IMG_H      (28),
      .NUM_SLOTS  (4),
      .SLOT_BITS  (2),
      .ADDR_BITS  (10),
      .GAP_CYCLES (0),
      .TIMEOUT    (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},     32'(bus.busy),            32'h0);
      check_eq({tag, "_pvalid"},   32'(bus.pix_valid),       32'h0);
      check_eq({tag, "_pdata"},    32'(bus.pix_data),        32'h0);
      check_eq({tag, "_plast"},    32'(bus.pix_last),        32'h0);
      check_eq({tag, "_rvalid"},   32'(bus.res_valid),       32'h0);
      check_eq({tag, "_rslot"},    32'(bus.res_slot),        32'h0);
      check_eq({tag, "_rdec"},     32'(bus.res_decision),    32'h0);
      check_eq({tag, "_rtimeout"}, 32'(bus.res_timeout),     32'h0);
      check_eq({tag, "_err"},      32'(bus.err_wr_conflict), 32'h0);
   endtask

   task automatic start_slot(input logic [1:0] slot);
      bus.start      = 1'b1;
      bus.start_slot = slot;
      tick();
      bus.start      = 1'b0;
   endtask

   initial begin
      int  exp_idx;
      int  n;
      bit  stalled;
      bit  r;
      logic [7:0] held;

      rst                 = 1'b1;
      bus.wr_en           = 1'b0;
      bus.wr_slot         = 2'd0;
      bus.wr_addr         = 10'd0;
      bus.wr_data         = 8'd0;
      bus.start           = 1'b0;
      bus.start_slot      = 2'd0;
      bus.pix_ready       = 1'b1;
      bus.res_in_valid    = 1'b0;
      bus.res_in_decision = 4'd0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;

      // slot 2: pixel value is the low byte of its address
      for (int a = 0; a < NPIX; a++) begin
         bus.wr_en   = 1'b1;
         bus.wr_slot = 2'd2;
         bus.wr_addr = 10'(a);
         bus.wr_data = 8'(a);
         tick();
      end
      bus.wr_en = 1'b0;

      // full frame at one pixel per cycle; a stray result mid-stream is ignored
      start_slot(2'd2);
      for (int k = 0; k < NPIX; k++) begin
         if (k == 0) check_eq("t1_busy", 32'(bus.busy), 32'h1);
         check_eq("t1_valid", 32'(bus.pix_valid), 32'h1);
         check_eq("t1_data",  32'(bus.pix_data),  32'(k % 256));
         check_eq("t1_last",  32'(bus.pix_last),  32'(k == NPIX - 1));
         if (k == 101) check_eq("t1_stray_res", 32'(bus.res_valid), 32'h0);
         bus.res_in_valid    = (k == 100);
         bus.res_in_decision = 4'd5;
         tick();
      end
      bus.res_in_valid = 1'b0;
      check_eq("t1_done_valid", 32'(bus.pix_valid), 32'h0);
      check_eq("t1_wait_busy",  32'(bus.busy),      32'h1);
      repeat (49) tick();
      bus.res_in_valid    = 1'b1;
      bus.res_in_decision = 4'd7;
      tick();
      bus.res_in_valid = 1'b0;
      check_eq("t1_res_valid",   32'(bus.res_valid),    32'h1);
      check_eq("t1_res_slot",    32'(bus.res_slot),     32'h2);
      check_eq("t1_res_dec",     32'(bus.res_decision), 32'h7);
      check_eq("t1_res_timeout", 32'(bus.res_timeout),  32'h0);
      check_eq("t1_idle_busy",   32'(bus.busy),         32'h0);
      tick();
      check_eq("t1_res_pulse",   32'(bus.res_valid),    32'h0);

      // back-pressure: random ready, data must hold during stalls
      start_slot(2'd2);
      exp_idx = 0;
      stalled = 1'b0;
      held    = 8'd0;
      n       = 0;
      while (exp_idx < NPIX && n < 4000) begin
         r = ($urandom_range(0, 2) != 0);
         bus.pix_ready = r;
         if (stalled) begin
            check_eq("t2_stall_valid", 32'(bus.pix_valid), 32'h1);
            check_eq("t2_stall_data",  32'(bus.pix_data),  32'(held));
         end
         if (bus.pix_valid && r) begin
            check_eq("t2_data", 32'(bus.pix_data), 32'(exp_idx % 256));
            check_eq("t2_last", 32'(bus.pix_last), 32'(exp_idx == NPIX - 1));
            exp_idx++;
            stalled = 1'b0;
         end else if (bus.pix_valid) begin
            stalled = 1'b1;
            held    = bus.pix_data;
         end else begin
            stalled = 1'b0;
         end
         tick();
         n++;
      end
      bus.pix_ready = 1'b1;
      check_eq("t2_count", 32'(exp_idx), 32'(NPIX));

      // no result: timeout after TO cycles in WAIT_RES
      n = 0;
      while (!bus.res_valid && n < 200) begin
         tick();
         n++;
      end
      check_eq("t3_to_cycles",  32'(n),                 32'(TO));
      check_eq("t3_to_valid",   32'(bus.res_valid),     32'h1);
      check_eq("t3_to_dec",     32'(bus.res_decision),  32'hF);
      check_eq("t3_to_flag",    32'(bus.res_timeout),   32'h1);
      check_eq("t3_to_slot",    32'(bus.res_slot),      32'h2);

      // result arriving on the final WAIT_RES cycle beats the timeout
      start_slot(2'd2);
      repeat (NPIX) tick();
      repeat (TO - 1) tick();
      bus.res_in_valid    = 1'b1;
      bus.res_in_decision = 4'd3;
      tick();
      bus.res_in_valid = 1'b0;
      check_eq("t4_valid",   32'(bus.res_valid),    32'h1);
      check_eq("t4_dec",     32'(bus.res_decision), 32'h3);
      check_eq("t4_timeout", 32'(bus.res_timeout),  32'h0);

      // write conflicts, writes to other slots, start while busy
      start_slot(2'd2);
      for (int k = 0; k < NPIX; k++) begin
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
         if (k == 10) begin
            bus.wr_en = 1'b1; bus.wr_slot = 2'd2; bus.wr_addr = 10'd500; bus.wr_data = 8'hAA;
         end
         if (k == 11) begin
            check_eq("t5_err_pulse", 32'(bus.err_wr_conflict), 32'h1);
            bus.wr_en = 1'b1; bus.wr_slot = 2'd1; bus.wr_addr = 10'd0; bus.wr_data = 8'h77;
         end
         if (k == 12) check_eq("t5_err_other", 32'(bus.err_wr_conflict), 32'h0);
         if (k == 20) begin
            bus.start = 1'b1; bus.start_slot = 2'd1;
         end
         if (k == 21)  check_eq("t5_start_ign", 32'(bus.pix_data), 32'h15);
         if (k == 500) check_eq("t5_no_write",  32'(bus.pix_data), 32'hF4);
         if (k == NPIX - 1) check_eq("t5_last", 32'(bus.pix_last), 32'h1);
         tick();
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      bus.res_in_valid    = 1'b1;
      bus.res_in_decision = 4'd9;
      tick();
      bus.res_in_valid = 1'b0;
      check_eq("t5_res_valid", 32'(bus.res_valid),    32'h1);
      check_eq("t5_res_slot",  32'(bus.res_slot),     32'h2);
      check_eq("t5_res_dec",   32'(bus.res_decision), 32'h9);
      start_slot(2'd1);
      check_eq("t5_s1_busy",   32'(bus.busy),      32'h1);
      check_eq("t5_s1_valid",  32'(bus.pix_valid), 32'h1);
      check_eq("t5_s1_data",   32'(bus.pix_data),  32'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t5_abort_busy", 32'(bus.busy), 32'h0);

      // reset at pixel 300, then restart from pixel 0 with intact data
      start_slot(2'd2);
      repeat (300) tick();
      check_eq("t6_pix300", 32'(bus.pix_data), 32'h2C);
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      tick();
      check_eq("t6_idle_busy", 32'(bus.busy), 32'h0);
      start_slot(2'd2);
      for (int k = 0; k < 4; k++) begin
         check_eq("t6_restart_data", 32'(bus.pix_data), 32'(k));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
